// File: rtl/wb_regfile.sv
// wb_regfile
// Write-back stage and architectural register file of the 16-bit pipeline.
// It selects the write-back result from the MEM/WB register outputs, commits
// it to the register array, serves two combinational decode read ports with
// same-cycle write-through bypass, and exports the write-back result to the
// execute-stage forwarding unit.
//
// Ports:
//   clk          clock; all state changes on posedge
//   reset        synchronous, active-high; clears every register
//   wb_sel       result select: 00 ALU, 01 shift, 10 memory, 11 link PC
//   wb_link_pc   return address for link instructions
//   wb_addr      destination register
//   wb_alu       ALU result
//   wb_shift     shifter result
//   wb_mem       data-memory read data
//   wb_regwrite  destination write enable
//   rd_addr_a/b  decode read port addresses
//   rd_data_a/b  decode read port data (combinational, bypassed)
//   fwd_data     selected write-back result
//   fwd_addr     destination register of fwd_data
//   fwd_valid    fwd_data will be committed at the next posedge
module wb_regfile #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        wb_sel,
    input  logic [DATA_W-1:0] wb_link_pc,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_alu,
    input  logic [DATA_W-1:0] wb_shift,
    input  logic [DATA_W-1:0] wb_mem,
    input  logic              wb_regwrite,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [DATA_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic              fwd_valid
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    logic [DATA_W-1:0] wb_result;
    logic              suppressed;
    logic              commit;

    // True when the address is r0 and r0 is hard-wired to zero.
    function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == {ADDR_W{1'b0}});
    endfunction

    // One read port: hard zero for r0, bypass of the committing write,
    // otherwise the stored array contents.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic              bypass_en,
        input logic [ADDR_W-1:0] bypass_addr,
        input logic [DATA_W-1:0] bypass_data,
        input logic [DATA_W-1:0] stored
    );
        logic [DATA_W-1:0] value;
        if (is_zero_reg(addr)) begin
            value = {DATA_W{1'b0}};
        end else if (bypass_en && (addr == bypass_addr)) begin
            value = bypass_data;
        end else begin
            value = stored;
        end
        return value;
    endfunction

    // Write-back result selection; width-exact, no extension.
    always_comb begin
        wb_result = wb_alu;
        case (wb_sel)
            2'b00:   wb_result = wb_alu;
            2'b01:   wb_result = wb_shift;
            2'b10:   wb_result = wb_mem;
            2'b11:   wb_result = wb_link_pc;
            default: wb_result = wb_alu;
        endcase
    end

    // A write commits only outside reset and when not aimed at a hard-zero r0;
    // the same qualifier gates bypass and fwd_valid.
    always_comb begin
        suppressed = is_zero_reg(wb_addr);
        commit     = wb_regwrite & ~reset & ~suppressed;
    end

    // Next-state of the register array: reset clears, else commit one entry.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = {DATA_W{1'b0}};
            end
        end else if (commit) begin
            regs_d[wb_addr] = wb_result;
        end else begin
            regs_d[wb_addr] = regs_q[wb_addr];
        end
    end

    // Register array state.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= regs_d[i];
        end
    end

    // Decode read ports with independent write-through bypass.
    always_comb begin
        rd_data_a = read_port(rd_addr_a, commit, wb_addr, wb_result, regs_q[rd_addr_a]);
        rd_data_b = read_port(rd_addr_b, commit, wb_addr, wb_result, regs_q[rd_addr_b]);
    end

    // Forwarding export to the execute stage.
    always_comb begin
        fwd_data  = wb_result;
        fwd_addr  = wb_addr;
        fwd_valid = commit;
    end

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

    logic        clk;
    logic        reset;
    logic [1:0]  wb_sel;
    logic [15:0] wb_link_pc;
    logic [3:0]  wb_addr;
    logic [15:0] wb_alu;
    logic [15:0] wb_shift;
    logic [15:0] wb_mem;
    logic        wb_regwrite;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic [15:0] fwd_data;
    logic [3:0]  fwd_addr;
    logic        fwd_valid;

    int n_total;
    int n_bad;

    wb_regfile #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .wb_sel     (wb_sel),
        .wb_link_pc (wb_link_pc),
        .wb_addr    (wb_addr),
        .wb_alu     (wb_alu),
        .wb_shift   (wb_shift),
        .wb_mem     (wb_mem),
        .wb_regwrite(wb_regwrite),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b),
        .fwd_data   (fwd_data),
        .fwd_addr   (fwd_addr),
        .fwd_valid  (fwd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a single ALU-sourced write for one cycle.
    task automatic write_alu(input logic [3:0] addr, input logic [15:0] val);
        wb_sel      = 2'b00;
        wb_addr     = addr;
        wb_alu      = val;
        wb_regwrite = 1'b1;
        tick();
        wb_regwrite = 1'b0;
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        reset       = 1'b1;
        wb_sel      = 2'b00;
        wb_link_pc  = 16'h0000;
        wb_addr     = 4'd0;
        wb_alu      = 16'h0000;
        wb_shift    = 16'h0000;
        wb_mem      = 16'h0000;
        wb_regwrite = 1'b0;
        rd_addr_a   = 4'd0;
        rd_addr_b   = 4'd0;
        tick();
        tick();
        reset = 1'b0;

        // Fill every writable register with all ones.
        for (int i = 1; i < 16; i++) begin
            write_alu(i[3:0], 16'hFFFF);
        end
        rd_addr_a = 4'd15;
        rd_addr_b = 4'd1;
        #1;
        check_eq("fill_r15", {16'h0, rd_data_a}, 32'h0000FFFF);
        check_eq("fill_r1", {16'h0, rd_data_b}, 32'h0000FFFF);

        // Reset with a pending write: no forward, no bypass.
        reset       = 1'b1;
        wb_regwrite = 1'b1;
        wb_addr     = 4'd4;
        wb_alu      = 16'h0ABC;
        rd_addr_a   = 4'd4;
        #1;
        check_eq("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
        check_eq("rst_no_bypass", {16'h0, rd_data_a}, 32'h0000FFFF);
        tick();
        reset       = 1'b0;
        wb_regwrite = 1'b0;
        wb_alu      = 16'h0000;
        wb_addr     = 4'd0;
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = a[3:0];
            rd_addr_b = 4'(15 - a);
            #1;
            check_eq($sformatf("rst_a%0d", a), {16'h0, rd_data_a}, 32'h0);
            check_eq($sformatf("rst_b%0d", 15 - a), {16'h0, rd_data_b}, 32'h0);
        end
        check_eq("post_rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);

        // Result mux sweep into r5.
        wb_alu      = 16'h1111;
        wb_shift    = 16'h2222;
        wb_mem      = 16'h3333;
        wb_link_pc  = 16'h4444;
        wb_addr     = 4'd5;
        wb_regwrite = 1'b1;
        rd_addr_a   = 4'd5;
        for (int s = 0; s < 4; s++) begin
            wb_sel = s[1:0];
            #1;
            check_eq($sformatf("mux_sel%0d", s), {16'h0, fwd_data}, 32'h1111 * (s + 1));
            check_eq($sformatf("mux_byp%0d", s), {16'h0, rd_data_a}, 32'h1111 * (s + 1));
            check_eq($sformatf("mux_valid%0d", s), {31'h0, fwd_valid}, 32'h1);
            check_eq($sformatf("mux_addr%0d", s), {28'h0, fwd_addr}, 32'h5);
            tick();
        end
        wb_regwrite = 1'b0;
        wb_sel      = 2'b00;
        #1;
        check_eq("mux_r5_held", {16'h0, rd_data_a}, 32'h00004444);

        // Dual-port bypass on r3.
        write_alu(4'd3, 16'h00AA);
        rd_addr_a = 4'd3;
        rd_addr_b = 4'd3;
        #1;
        check_eq("byp_pre_r3", {16'h0, rd_data_a}, 32'h000000AA);
        wb_addr     = 4'd3;
        wb_alu      = 16'h0BEE;
        wb_regwrite = 1'b1;
        #1;
        check_eq("byp_a_same", {16'h0, rd_data_a}, 32'h00000BEE);
        check_eq("byp_b_same", {16'h0, rd_data_b}, 32'h00000BEE);
        tick();
        wb_regwrite = 1'b0;
        #1;
        check_eq("byp_a_after", {16'h0, rd_data_a}, 32'h00000BEE);
        check_eq("byp_b_after", {16'h0, rd_data_b}, 32'h00000BEE);

        // Independent bypass: port A bypasses, port B reads stored r5.
        wb_addr     = 4'd3;
        wb_alu      = 16'h0C0C;
        wb_regwrite = 1'b1;
        rd_addr_b   = 4'd5;
        #1;
        check_eq("indep_a", {16'h0, rd_data_a}, 32'h00000C0C);
        check_eq("indep_b", {16'h0, rd_data_b}, 32'h00004444);
        tick();
        wb_regwrite = 1'b0;

        // Back-to-back writes to r2: later wins, each bypassed in its cycle.
        rd_addr_a   = 4'd2;
        wb_addr     = 4'd2;
        wb_alu      = 16'h0101;
        wb_regwrite = 1'b1;
        #1;
        check_eq("b2b_first", {16'h0, rd_data_a}, 32'h00000101);
        tick();
        wb_alu = 16'h0202;
        #1;
        check_eq("b2b_second", {16'h0, rd_data_a}, 32'h00000202);
        tick();
        wb_regwrite = 1'b0;
        #1;
        check_eq("b2b_final", {16'h0, rd_data_a}, 32'h00000202);

        // Zero register ignores writes.
        wb_addr     = 4'd0;
        wb_alu      = 16'h1234;
        wb_regwrite = 1'b1;
        rd_addr_a   = 4'd0;
        #1;
        check_eq("zero_same", {16'h0, rd_data_a}, 32'h0);
        check_eq("zero_valid", {31'h0, fwd_valid}, 32'h0);
        check_eq("zero_fwd_data", {16'h0, fwd_data}, 32'h00001234);
        tick();
        wb_regwrite = 1'b0;
        #1;
        check_eq("zero_after", {16'h0, rd_data_a}, 32'h0);

        // Gated write to r7.
        write_alu(4'd7, 16'h0777);
        wb_addr   = 4'd7;
        wb_alu    = 16'hDEAD;
        wb_sel    = 2'b00;
        rd_addr_a = 4'd7;
        #1;
        check_eq("gate_same", {16'h0, rd_data_a}, 32'h00000777);
        check_eq("gate_valid", {31'h0, fwd_valid}, 32'h0);
        tick();
        #1;
        check_eq("gate_after", {16'h0, rd_data_a}, 32'h00000777);

        // Reset colliding with a write to r9.
        write_alu(4'd9, 16'h5555);
        rd_addr_a = 4'd9;
        #1;
        check_eq("coll_pre", {16'h0, rd_data_a}, 32'h00005555);
        reset       = 1'b1;
        wb_addr     = 4'd9;
        wb_alu      = 16'h7777;
        wb_regwrite = 1'b1;
        #1;
        check_eq("coll_same", {16'h0, rd_data_a}, 32'h00005555);
        check_eq("coll_valid", {31'h0, fwd_valid}, 32'h0);
        tick();
        reset       = 1'b0;
        wb_regwrite = 1'b0;
        #1;
        check_eq("coll_after", {16'h0, rd_data_a}, 32'h0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and architectural register file of the 16-bit five-stage pipeline. It sits directly downstream of the MEM/WB pipeline register and takes that register's outputs. It selects the write-back result, commits it to a 16-entry register file, and serves the two decode-stage read ports with same-cycle write-through bypass. It also exports the current write-back result to the execute-stage forwarding unit.

## Interface
Parameters:
- DATA_W, 16, register and result width
- ADDR_W, 4, register address width; the file holds 2**ADDR_W registers
- ZERO_REG, 1, when 1, r0 reads as 0 and ignores writes

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- wb_sel  in  2  result select: 00 ALU, 01 shift, 10 memory read data, 11 link PC
- wb_link_pc  in  DATA_W  return address for link instructions
- wb_addr  in  ADDR_W  destination register
- wb_alu  in  DATA_W  ALU result
- wb_shift  in  DATA_W  shifter result
- wb_mem  in  DATA_W  data-memory read data
- wb_regwrite  in  1  write enable for the destination register
- rd_addr_a  in  ADDR_W  decode read port A address
- rd_addr_b  in  ADDR_W  decode read port B address
- rd_data_a  out  DATA_W  port A data (combinational)
- rd_data_b  out  DATA_W  port B data (combinational)
- fwd_data  out  DATA_W  selected write-back result
- fwd_addr  out  ADDR_W  destination register of fwd_data
- fwd_valid  out  1  fwd_data will be committed at the next posedge

## Operation
- wb_result = mux(wb_sel) over {wb_alu, wb_shift, wb_mem, wb_link_pc}. The mux is purely combinational and width-exact; there is no extension or truncation.
- Commit: at posedge clk, when reset=0, wb_regwrite=1 and the write is not suppressed, regs[wb_addr] <= wb_result.
- Suppressed write: ZERO_REG=1 and wb_addr=0. The register is not written, fwd_valid=0, and no bypass occurs.
- Read: rd_data_x = regs[rd_addr_x], or wb_result when the bypass condition holds.
- Bypass condition for port x: reset=0, wb_regwrite=1, rd_addr_x == wb_addr, and the write is not suppressed. Both ports bypass independently, and both may bypass in the same cycle.
- Reading r0 with ZERO_REG=1 always returns 0.
- fwd_data = wb_result at all times. fwd_addr = wb_addr. fwd_valid = wb_regwrite & ~reset & ~suppressed.
- The block has one write port. The MEM/WB register supplies at most one write per cycle, so there is no arbitration.

## Timing
- Reset: every register is cleared to 0 at a posedge with reset=1. While reset=1, no write is committed, bypass is disabled and fwd_valid=0. rd_data_x shows the stored contents, which are 0 from the first reset edge onward.
- Reset in the same cycle as wb_regwrite=1: the write is discarded and the register holds 0 after the edge.
- Outputs after reset: rd_data_a=rd_data_b=0 for every address, fwd_valid=0. fwd_data and fwd_addr follow their inputs, which are 0 coming out of the reset MEM/WB register.
- Write latency: a write is visible to the read ports in the same cycle through the bypass, and from the array from the next cycle onward. This gives the decode stage write-before-read semantics, so no extra stall is needed.
- Read latency: 0 cycles, combinational from rd_addr_x and the write-back inputs.
- Back-to-back writes to the same register: the later write wins. Each write is bypassed during its own cycle.
- wb_regwrite=0: there is no state change and no bypass, regardless of wb_addr or wb_sel.

## Test plan
- Reset: fill every register with 0xFFFF, assert reset for one edge, read addresses 0..15 on both ports -> all read 0x0000, fwd_valid=0.
- Result mux: wb_alu=0x1111, wb_shift=0x2222, wb_mem=0x3333, wb_link_pc=0x4444, wb_addr=5, regwrite=1, sweep wb_sel 00..11 over four cycles -> fwd_data is 0x1111, 0x2222, 0x3333, 0x4444 in turn; r5 holds 0x4444 afterwards.
- Bypass: r3 holds 0x00AA, write r3 <= 0x0BEE, with rd_addr_a=rd_addr_b=3 in the same cycle -> both ports read 0x0BEE before the edge and keep reading 0x0BEE after it.
- Zero register: ZERO_REG=1, write r0 <= 0x1234, rd_addr_a=0 -> rd_data_a=0 in the write cycle and afterwards; fwd_valid=0.
- Write gated: regwrite=0, wb_addr=7, wb_alu=0xDEAD, wb_sel=00 -> r7 is unchanged, no bypass on rd_addr_a=7, fwd_valid=0.
- Reset collision: r9=0x5555, then in one cycle reset=1 with a write r9 <= 0x7777 -> r9=0x0000 after the edge; rd_data_a at address 9 reads 0x0000 and never shows 0x7777.
